// File: rtl/cronometro_parametrizado.sv
// cronometro_parametrizado: N-digit BCD stopwatch/timer with lap freeze and direct seven-segment drive
module cronometro_parametrizado #(
  parameter int N_DIGITOS = 4,
  parameter int DIV_TICK = 50000,
  parameter int SEG_ATIVO_BAIXO = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_conta,
  input  logic btn_pausa,
  input  logic btn_para,
  input  logic btn_zera,
  input  logic btn_volta,
  input  logic modo,
  input  logic [4*N_DIGITOS-1:0] preset,
  output logic [7*N_DIGITOS-1:0] displays,
  output logic [1:0] estado,
  output logic fim,
  output logic volta_ativa
);
  localparam int W = 4*N_DIGITOS;
  localparam int PW = $clog2(DIV_TICK);
  localparam logic [PW-1:0] PMAX = PW'(DIV_TICK-1);
  typedef enum logic [1:0] {ZERADO, CONTANDO, PAUSADO, PARADO} estado_t;
  estado_t st, st_n;
  logic [4:0] s1, s2, s3, pulso;
  logic p_conta, p_pausa, p_para, p_zera, p_volta;
  logic [W-1:0] contagem, disp, inc, dec, carga_val;
  logic [PW-1:0] presc;
  logic modo_lat, run, tick, carga, fim_set, alterna, vazio, dec_zero;
  logic c, b;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= {btn_volta, btn_zera, btn_para, btn_pausa, btn_conta};
      s2 <= s1;
      s3 <= s2;
    end
  assign pulso = s3 & ~s2;
  assign {p_volta, p_zera, p_para, p_pausa, p_conta} = pulso;
  // decimal carry/borrow chains and the clamped preset
  always_comb begin
    inc = contagem;
    dec = contagem;
    carga_val = preset;
    c = 1'b1;
    b = 1'b1;
    for (int k = 0; k < N_DIGITOS; k++) begin
      inc[4*k+:4] = c ? (contagem[4*k+:4] == 4'd9 ? 4'd0 : contagem[4*k+:4] + 4'd1) : contagem[4*k+:4];
      dec[4*k+:4] = b ? (contagem[4*k+:4] == 4'd0 ? 4'd9 : contagem[4*k+:4] - 4'd1) : contagem[4*k+:4];
      c = c && contagem[4*k+:4] == 4'd9;
      b = b && contagem[4*k+:4] == 4'd0;
      carga_val[4*k+:4] = preset[4*k+:4] > 4'd9 ? 4'd9 : preset[4*k+:4];
    end
  end
  assign vazio = contagem == '0;
  assign dec_zero = dec == '0;
  // a cycle that carries a pause/stop/clear event does not advance the count
  assign run = st == CONTANDO && !(p_zera || p_para || p_pausa) && !(modo_lat && vazio);
  assign tick = run && presc == PMAX;
  always_comb begin
    st_n = st;
    carga = 1'b0;
    fim_set = 1'b0;
    case (st)
      ZERADO:
        if (p_conta) begin
          st_n = CONTANDO;
          carga = 1'b1;
        end
      CONTANDO:
        if (p_zera) st_n = ZERADO;
        else if (p_para) st_n = PARADO;
        else if (p_pausa) st_n = PAUSADO;
        else if (modo_lat && (vazio || (tick && dec_zero))) begin
          st_n = PARADO;
          fim_set = 1'b1;
        end
      PAUSADO:
        if (p_zera) st_n = ZERADO;
        else if (p_para) st_n = PARADO;
        else if (p_conta) st_n = CONTANDO;
      default:
        if (p_zera) st_n = ZERADO;
        else if (p_conta) begin
          st_n = CONTANDO;
          carga = 1'b1;
        end
    endcase
  end
  assign alterna = p_volta && (st == CONTANDO || st == PAUSADO) && st_n == st;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= ZERADO;
      contagem <= '0;
      presc <= '0;
      disp <= '0;
      modo_lat <= 1'b0;
      fim <= 1'b0;
      volta_ativa <= 1'b0;
    end else begin
      st <= st_n;
      presc <= (carga || !(st_n == CONTANDO || st_n == PAUSADO) || tick) ? '0 : run ? presc + PW'(1) : presc;
      contagem <= st_n == ZERADO ? '0 : carga ? (modo ? carga_val : '0) : tick ? (modo_lat ? dec : inc) : contagem;
      fim <= (st_n == ZERADO || carga) ? 1'b0 : fim | fim_set;
      volta_ativa <= (st_n == ZERADO || st_n == PARADO) ? 1'b0 : volta_ativa ^ alterna;
      modo_lat <= carga ? modo : modo_lat;
      disp <= volta_ativa ? disp : contagem;
    end
  assign estado = st;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h7E;
      4'd1: seg7 = 7'h30;
      4'd2: seg7 = 7'h6D;
      4'd3: seg7 = 7'h79;
      4'd4: seg7 = 7'h33;
      4'd5: seg7 = 7'h5B;
      4'd6: seg7 = 7'h5F;
      4'd7: seg7 = 7'h70;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h7B;
      default: seg7 = 7'h00;
    endcase
  endfunction
  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_seg
    assign displays[7*g+:7] = (SEG_ATIVO_BAIXO != 0) ? ~seg7(disp[4*g+:4]) : seg7(disp[4*g+:4]);
  end
endmodule

// File: tb/tb_cronometro_parametrizado.sv
// tb_cronometro_parametrizado: directed vector table plus hand sequences for the 4-digit, DIV_TICK=2 build
module tb_cronometro_parametrizado;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] pins = '1;
  logic modo = 1'b0;
  logic [15:0] preset = '0;
  logic [27:0] displays;
  logic [1:0] estado;
  logic fim, volta_ativa;
  int total = 0;
  int bad = 0;
  string letras [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  cronometro_parametrizado #(.N_DIGITOS(4), .DIV_TICK(2), .SEG_ATIVO_BAIXO(1)) dut (
    .clk(clk), .rst(rst),
    .btn_conta(pins[0]), .btn_pausa(pins[1]), .btn_para(pins[2]), .btn_zera(pins[3]), .btn_volta(pins[4]),
    .modo(modo), .preset(preset), .displays(displays), .estado(estado), .fim(fim), .volta_ativa(volta_ativa)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] exp_disp(input logic [15:0] v);
    logic [27:0] r;
    logic [6:0] s;
    string t;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = '0;
      t = letras[v[4*k+:4]];
      for (int i = 0; i < t.len(); i++) s[6 - (int'(t[i]) - 97)] = 1'b1;
      r[7*k+:7] = ~s;
    end
    return r;
  endfunction

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nome, act, exp);
    end
  endtask

  task automatic press(input int b);
    pins[b] = 1'b0;
    repeat (4) @(negedge clk);
    pins[b] = 1'b1;
  endtask

  typedef struct {
    int btn;
    logic modo;
    logic [15:0] preset;
    int espera;
    logic [1:0] estado;
    logic [15:0] valor;
    logic fim;
    logic volta;
  } vec_t;
  vec_t tab [21];

  initial begin
    int n;
    tab[0]  = '{-1, 1'b0, 16'h0000, 2,  2'd0, 16'h0000, 1'b0, 1'b0};
    tab[1]  = '{0,  1'b0, 16'h0000, 20, 2'd1, 16'h0010, 1'b0, 1'b0};
    tab[2]  = '{1,  1'b0, 16'h0000, 20, 2'd2, 16'h0011, 1'b0, 1'b0};
    tab[3]  = '{0,  1'b0, 16'h0000, 1,  2'd1, 16'h0012, 1'b0, 1'b0};
    tab[4]  = '{4,  1'b0, 16'h0000, 10, 2'd1, 16'h0013, 1'b0, 1'b1};
    tab[5]  = '{4,  1'b0, 16'h0000, 4,  2'd1, 16'h0023, 1'b0, 1'b0};
    tab[6]  = '{4,  1'b0, 16'h0000, 0,  2'd1, 16'h0024, 1'b0, 1'b1};
    tab[7]  = '{2,  1'b0, 16'h0000, 4,  2'd3, 16'h0026, 1'b0, 1'b0};
    tab[8]  = '{4,  1'b0, 16'h0000, 0,  2'd3, 16'h0026, 1'b0, 1'b0};
    tab[9]  = '{3,  1'b0, 16'h0000, 0,  2'd0, 16'h0000, 1'b0, 1'b0};
    tab[10] = '{0,  1'b1, 16'h0003, 0,  2'd1, 16'h0003, 1'b0, 1'b0};
    tab[11] = '{-1, 1'b1, 16'h0003, 2,  2'd1, 16'h0002, 1'b0, 1'b0};
    tab[12] = '{-1, 1'b1, 16'h0003, 2,  2'd1, 16'h0001, 1'b0, 1'b0};
    tab[13] = '{-1, 1'b1, 16'h0003, 2,  2'd3, 16'h0000, 1'b1, 1'b0};
    tab[14] = '{0,  1'b1, 16'h0003, 0,  2'd1, 16'h0003, 1'b0, 1'b0};
    tab[15] = '{3,  1'b1, 16'h0003, 0,  2'd0, 16'h0000, 1'b0, 1'b0};
    tab[16] = '{0,  1'b1, 16'h0000, 0,  2'd3, 16'h0000, 1'b1, 1'b0};
    tab[17] = '{3,  1'b1, 16'h0000, 0,  2'd0, 16'h0000, 1'b0, 1'b0};
    tab[18] = '{0,  1'b1, 16'h00A5, 0,  2'd1, 16'h0095, 1'b0, 1'b0};
    tab[19] = '{-1, 1'b0, 16'h00A5, 2,  2'd1, 16'h0094, 1'b0, 1'b0};
    tab[20] = '{3,  1'b0, 16'h0000, 0,  2'd0, 16'h0000, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      modo = tab[i].modo;
      preset = tab[i].preset;
      if (tab[i].btn >= 0) press(tab[i].btn);
      repeat (tab[i].espera) @(negedge clk);
      chk($sformatf("v%0d estado", i), 32'(estado), 32'(tab[i].estado));
      chk($sformatf("v%0d displays", i), 32'(displays), 32'(exp_disp(tab[i].valor)));
      chk($sformatf("v%0d fim", i), 32'(fim), 32'(tab[i].fim));
      chk($sformatf("v%0d volta", i), 32'(volta_ativa), 32'(tab[i].volta));
    end
    // zera and conta fall together while counting, both held 100 cycles
    modo = 1'b0;
    press(0);
    repeat (10) @(negedge clk);
    pins[0] = 1'b0;
    pins[3] = 1'b0;
    repeat (100) @(negedge clk);
    chk("zera_conta estado", 32'(estado), 32'd0);
    chk("zera_conta displays", 32'(displays), 32'(exp_disp(16'h0000)));
    pins[0] = 1'b1;
    pins[3] = 1'b1;
    repeat (5) @(negedge clk);
    // up-count wrap from 9999
    press(0);
    n = 0;
    while (displays !== exp_disp(16'h9999) && n < 25000) begin
      @(negedge clk);
      n++;
    end
    chk("wrap reach9999", 32'(displays), 32'(exp_disp(16'h9999)));
    repeat (2) @(negedge clk);
    chk("wrap displays", 32'(displays), 32'(exp_disp(16'h0000)));
    chk("wrap estado", 32'(estado), 32'd1);
    chk("wrap fim", 32'(fim), 32'd0);
    // asynchronous reset in the middle of a count
    n = 0;
    while (displays !== exp_disp(16'h0123) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rst reach0123", 32'(displays), 32'(exp_disp(16'h0123)));
    #2 rst = 1'b1;
    #1;
    chk("rst estado", 32'(estado), 32'd0);
    chk("rst displays", 32'(displays), 32'(exp_disp(16'h0000)));
    chk("rst fim", 32'(fim), 32'd0);
    chk("rst volta", 32'(volta_ativa), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst estado", 32'(estado), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cronometro_parametrizado.md
Name: cronometro_parametrizado

Overview:
Parametrised successor to the 4-digit board stopwatch. It counts N BCD digits at a prescaled tick rate, in up (stopwatch) or down (timer from preset) mode. It supports a lap/split freeze of the display while counting continues, and drives N seven-segment displays directly. Buttons come from the board pushbuttons (active-low, asynchronous); everything else is synchronous to clk.

Parameters:
N_DIGITOS, 4, number of BCD digits and displays (1..8)
DIV_TICK, 50000, clk cycles per count step (>=2)
SEG_ATIVO_BAIXO, 1, 1 = segment lit by 0, 0 = lit by 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
btn_conta  in  1  start/resume, active-low, async
btn_pausa  in  1  pause, active-low, async
btn_para  in  1  stop, active-low, async
btn_zera  in  1  clear, active-low, async
btn_volta  in  1  lap toggle, active-low, async
modo  in  1  0 = count up, 1 = count down
preset  in  4*N_DIGITOS  BCD start value for down mode; digit k at [4k+3:4k]
displays  out  7*N_DIGITOS  segments; digit k at [7k+6:7k]; in each field MSB = a ... LSB = g
estado  out  2  0 ZERADO, 1 CONTANDO, 2 PAUSADO, 3 PARADO
fim  out  1  high while down count sits at zero after expiring
volta_ativa  out  1  display frozen by lap

Behaviour:
- Reset (rst high, any time, async): estado = ZERADO; count = 0; prescaler = 0; display register = 0; volta_ativa = 0; fim = 0; synchronizers = idle (1). displays shows all digits "0" with polarity per SEG_ATIVO_BAIXO.
- Buttons: each passes through a 2-flop synchronizer. A falling edge on the synchronized level yields a 1-cycle pulse. State changes on the 3rd rising clk after the pin falls. A held button produces a single pulse only.
- Priority when several pulses occur in the same cycle: zera > para > pausa > conta > volta.
- FSM (rising clk):
  - ZERADO: conta -> CONTANDO. modo_lat <= modo. count <= preset if modo = 1, else 0.
  - CONTANDO: pausa -> PAUSADO; para -> PARADO; zera -> ZERADO.
  - PAUSADO: conta -> CONTANDO (resume from held value); para -> PARADO; zera -> ZERADO.
  - PARADO: conta -> CONTANDO and reload as from ZERADO (re-latch modo, count <= preset or 0); zera -> ZERADO.
  - ZERADO clears count, prescaler, volta_ativa and fim.
- modo is sampled only on transitions from ZERADO or PARADO into CONTANDO. Changing it at other times has no effect.
- Prescaler:
  - runs only in CONTANDO; counts 0..DIV_TICK-1; a tick is issued in the cycle it wraps;
  - holds its value in PAUSADO;
  - clears in ZERADO and PARADO and on every reload.
- Count is a cascaded BCD counter; each digit is 0..9.
  - Up mode: on tick, increment with decimal carry. All-9s wraps to all-0s; no flag is raised.
  - Down mode: on tick, decrement with decimal borrow. When a tick brings count to 0, the next state is PARADO and fim = 1. fim stays 1 until the next reload, zera or rst.
  - Entering CONTANDO in down mode with preset = 0: immediately go to PARADO with fim = 1 on the next cycle.
  - A preset digit > 9 is clamped to 9 at load.
- Display register:
  - follows count every cycle while volta_ativa = 0;
  - holds while volta_ativa = 1.
- volta toggles volta_ativa only in CONTANDO or PAUSADO; it is ignored in other states.
  - Leaving to ZERADO clears volta_ativa.
  - Entering PARADO clears volta_ativa, so the display shows the final count.
- displays is combinational from the display register through the 0..9 segment decoder: 0 = abcdef, 1 = bc, 2 = abdeg, 3 = abcdg, 4 = bcfg, 5 = acdfg, 6 = acdefg, 7 = abc, 8 = all, 9 = abcdfg. Codes > 9 (unreachable) blank the digit. All outputs are inverted when SEG_ATIVO_BAIXO = 1.
- Latency: tick to display update = 1 cycle.

Test Plan:
- rst pulse mid-count (count = 0123) -> estado = 0, displays all "0" immediately, fim = 0.
- DIV_TICK = 4, up mode, conta then wait 40 cycles -> count = 0010 (±1 tick by phase). pausa for 20 cycles -> value unchanged. conta -> resumes from the same value and prescaler phase.
- Up mode with count forced near 9999 -> one tick later 0000, estado stays 1, fim = 0.
- Down mode, preset = 0003, DIV_TICK = 2 -> 0002, 0001, 0000 every 2 cycles; then estado = 3, fim = 1. conta -> reloads 0003, fim = 0.
- Lap: counting up, volta at 0005 -> display frozen at 0005 while count continues. volta again at count 0009 -> display 0009. para -> volta_ativa = 0, display shows final count.
- Simultaneous btn_zera and btn_conta falling in the same cycle while CONTANDO -> estado = ZERADO, count = 0000. Button held 100 cycles -> exactly one transition.
